mips_muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the MIPS CPU, replacing the single-cycle HILO logic inside the ALU. It performs one result bit per clock, which removes the 32x32 multiplier and divider from the critical path. A start/busy/done handshake lets the control unit stall on MFHI/MFLO while an operation is in flight. HI/LO are exposed continuously for MFHI/MFLO; MTHI/MTLO writes complete in one cycle.

---
 rtl/mips_muldiv_unit.sv | 133 +++++++++++++
 tb/tb_mips_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one result bit per clock,
// start/busy/done handshake, single-cycle MTHI/MTLO writes when idle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Handshake: start is taken on a rising edge when the unit is IDLE (or, for
  // multiply/divide, on the edge leaving FIX); busy is high from the accepting
  // edge until the edge that writes HI/LO, which also raises done for one cycle.
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mag_b;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 div0;

  logic                 start_md;
  logic                 start_mt;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_r;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    start_md   = start && !op[2];
    start_mt   = start && op[2] && !op[1];
    a_neg      = op[0] && src_a[WIDTH-1];
    b_neg      = op[0] && src_b[WIDTH-1];
    a_mag      = a_neg ? -src_a : src_a;
    b_mag      = b_neg ? -src_b : src_b;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_addend = acc[0] ? mag_b : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    // Divide: acc = {partial remainder, dividend bits shifting out / quotient shifting in}.
    div_r      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff   = div_r - {1'b0, mag_b};
    if (!is_div)
      step_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step_next = {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix   = neg_res ? -acc : acc;
    quo_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mag_b   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIX: begin
          if (state == FIX) begin
            done <= 1'b1;
            if (!is_div)
              {hi, lo} <= prod_fix;
            else begin
              // Zero divisor: remainder path yields the dividend unchanged.
              hi <= rem_fix;
              lo <= div0 ? {WIDTH{1'b1}} : quo_fix;
            end
          end else if (start_mt) begin
            if (op[0]) lo <= src_a;
            else       hi <= src_a;
          end
          if (start_md) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            mag_b   <= op[1] ? b_mag : a_mag;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= op[1] && (src_b == '0);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus random
// multiply/divide operations against a 64-bit arithmetic reference model.
module tb_mips_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  int             tests;
  int             failed;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      OP_MULT:  p = 64'(sa * sb);
      OP_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Called at a negedge; returns just after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic finish_op(input bit inject, input int n0);
    int n;
    int busy_cnt;
    bit hold_ok;
    logic [2*W-1:0] e;
    n = n0;
    busy_cnt = n0;
    hold_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      if (inject && n == 5) begin
        start = 1'b1; op = OP_DIVU; src_a = 32'd7; src_b = 32'd2;
      end else if (inject && n == 6) begin
        op = OP_MTLO; src_a = 32'hDEAD_BEEF;
      end else if (inject && n == 7) begin
        start = 1'b0;
      end
      if (!inject && n > 2) begin
        src_a = $urandom; src_b = $urandom;
      end
    end
    check("latency", 64'(n), 64'(W + 2));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    check("hold_during_run", 64'(hold_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("hi_lo", {hi, lo}, e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(o, a, b);
    finish_op(1'b0, 0);
  endtask

  initial begin
    int quiet;
    logic [2*W-1:0] e;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    tests = 0; failed = 0;
    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    // Directed corner cases
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_const", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(OP_DIVU, 32'd7, 32'd2);
    do_op(OP_DIVU, 32'd7, 32'd0);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    check("mthi", 64'(hi), 64'h1234_5678);
    check("mthi_busy_done", {busy, done}, 64'd0);
    op = OP_MTLO; src_a = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    check("mtlo_busy_done", {busy, done}, 64'd0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // Starts during a multiply are ignored
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(1'b1, 0);
    check("lo_not_mtlo", 64'(lo == 32'hDEAD_BEEF), 64'd0);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) quiet++;
    end
    check("idle_quiet", 64'(quiet), 64'd0);

    // Back-to-back: next start accepted on the edge that leaves FIX
    launch(OP_DIV, 32'hFFFF_FF00, 32'd9);
    repeat (W + 1) @(negedge clk);
    check("fix_busy", {busy, done}, 64'd2);
    launch(OP_MULT, 32'h0001_2345, 32'hFFFF_8001);
    @(negedge clk);
    check("b2b_done_busy", {busy, done}, 64'd3);
    e = exp_q.pop_front();
    check("b2b_first", {hi, lo}, e);
    {m_hi, m_lo} = e;
    finish_op(1'b0, 1);

    // Reset aborts an operation in flight
    launch(OP_MULT, 32'd123, 32'd456);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {busy, done, hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || hi != 0 || lo != 0) quiet++;
    end
    check("abort_quiet", 64'(quiet), 64'd0);
    do_op(OP_MULT, 32'hFFFF_FF85, 32'h0000_1F40);

    // Random multiply/divide traffic
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
